// File: rtl/mem_byte_rmw_pkg.sv
// Shared definitions for the MEM-stage byte read-modify-write block.
//   SZ_BYTE/SZ_HALF/SZ_WORD : req_size encodings (2'b11 is illegal)
//   state_e                 : store FSM state (idle / pending RMW write)
package mem_byte_rmw_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/mem_byte_rmw_load_extend.sv
// Combinational load extractor: picks the byte/half addressed by addr_lo
// out of the two 16-bit RAM halves and sign- or zero-extends it to 32 bits.
// Ports:
//   size        in  2   access size (SZ_* encodings)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   addr_lo     in  2   byte address bits [1:0]
//   q_lo, q_hi  in  16  read data from the low / high RAM halves
//   rdata       out 32  extended load result (word loads pass through)
module load_extend
  import mem_byte_rmw_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [15:0] q_lo,
  input  logic [15:0] q_hi,
  output logic [31:0] rdata
);

  logic [15:0] half_val;
  logic [7:0]  byte_val;

  always_comb begin
    half_val = addr_lo[1] ? q_hi : q_lo;
    byte_val = addr_lo[0] ? half_val[15:8] : half_val[7:0];
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'h000000, byte_val}
                                   : {{24{byte_val[7]}}, byte_val};
      SZ_HALF: rdata = is_unsigned ? {16'h0000, half_val}
                                   : {{16{half_val[15]}}, half_val};
      default: rdata = {q_hi, q_lo};
    endcase
  end

endmodule

// File: rtl/mem_byte_rmw.sv
// MEM-stage access unit for a RAM built from two 16-bit halves.
// Loads are zero-latency; word/half stores write in one cycle; byte stores
// are a two-cycle read-modify-write (read+merge with stall, then write).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/we/size/unsigned request qualifiers
//   req_addr [11:0]            byte address
//   req_wdata [31:0]           right-aligned store data
//   ram_addr [9:0]             word index to both halves
//   ram_d_lo/hi, ram_we,
//   ram_sel_lo/hi              RAM write port
//   ram_q_lo/hi                async RAM read data
//   rdata [31:0]               extended load data
//   stall                      pipeline hold (byte-store read cycle)
//   misalign                   one-cycle registered error pulse
//   rmw_count [15:0]           saturating count of completed byte stores
module mem_byte_rmw
  import mem_byte_rmw_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [9:0]  ram_addr,
  output logic [15:0] ram_d_lo,
  output logic [15:0] ram_d_hi,
  output logic        ram_we,
  output logic        ram_sel_lo,
  output logic        ram_sel_hi,
  input  logic [15:0] ram_q_lo,
  input  logic [15:0] ram_q_hi,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic [15:0] rmw_count
);

  state_e      state_q, state_d;
  logic [9:0]  lat_addr_q, lat_addr_d;
  logic [15:0] lat_data_q, lat_data_d;
  logic        lat_sel_hi_q, lat_sel_hi_d;
  logic        misalign_q, misalign_d;
  logic [15:0] rmw_count_q, rmw_count_d;

  logic        illegal;
  logic [15:0] cur_half;
  logic [15:0] merged;
  logic [31:0] ext_rdata;

  load_extend u_load_extend (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .addr_lo     (req_addr[1:0]),
    .q_lo        (ram_q_lo),
    .q_hi        (ram_q_hi),
    .rdata       (ext_rdata)
  );

  always_comb begin
    illegal = (req_size == 2'b11)
            || ((req_size == SZ_HALF) && req_addr[0])
            || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    cur_half = req_addr[1] ? ram_q_hi : ram_q_lo;
    merged   = req_addr[0] ? {req_wdata[7:0], cur_half[7:0]}
                           : {cur_half[15:8], req_wdata[7:0]};
  end

  always_comb begin
    state_d      = state_q;
    lat_addr_d   = lat_addr_q;
    lat_data_d   = lat_data_q;
    lat_sel_hi_d = lat_sel_hi_q;
    misalign_d   = 1'b0;
    rmw_count_d  = rmw_count_q;

    ram_addr   = req_addr[11:2];
    ram_d_lo   = '0;
    ram_d_hi   = '0;
    ram_we     = 1'b0;
    ram_sel_lo = 1'b0;
    ram_sel_hi = 1'b0;
    stall      = 1'b0;
    rdata      = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            misalign_d = 1'b1;
          end else if (!req_we) begin
            rdata = ext_rdata;
          end else begin
            case (req_size)
              SZ_WORD: begin
                ram_we     = 1'b1;
                ram_sel_lo = 1'b1;
                ram_sel_hi = 1'b1;
                ram_d_lo   = req_wdata[15:0];
                ram_d_hi   = req_wdata[31:16];
              end
              SZ_HALF: begin
                ram_we     = 1'b1;
                ram_sel_lo = !req_addr[1];
                ram_sel_hi = req_addr[1];
                if (req_addr[1]) ram_d_hi = req_wdata[15:0];
                else             ram_d_lo = req_wdata[15:0];
              end
              default: begin
                // Byte store: capture the merged half now, write it next cycle.
                lat_addr_d   = req_addr[11:2];
                lat_data_d   = merged;
                lat_sel_hi_d = req_addr[1];
                stall        = 1'b1;
                state_d      = ST_WRITE;
              end
            endcase
          end
        end
      end
      ST_WRITE: begin
        // Driven purely from latched state; the live request is ignored.
        ram_addr   = lat_addr_q;
        ram_we     = 1'b1;
        ram_sel_lo = !lat_sel_hi_q;
        ram_sel_hi = lat_sel_hi_q;
        if (lat_sel_hi_q) ram_d_hi = lat_data_q;
        else              ram_d_lo = lat_data_q;
        if (rmw_count_q != 16'hFFFF) rmw_count_d = rmw_count_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lat_addr_q   <= '0;
      lat_data_q   <= '0;
      lat_sel_hi_q <= 1'b0;
      misalign_q   <= 1'b0;
      rmw_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_addr_q   <= lat_addr_d;
      lat_data_q   <= lat_data_d;
      lat_sel_hi_q <= lat_sel_hi_d;
      misalign_q   <= misalign_d;
      rmw_count_q  <= rmw_count_d;
    end
  end

  assign misalign  = misalign_q;
  assign rmw_count = rmw_count_q;

endmodule
